fp_accum_ctrl: RTL and testbench
================================

// Module: fp_accum_ctrl
// PURPOSE
//  Sequencer that accumulates a stream of FP32 values (e.g. 5x5 conv products) through
//  one shared fp_add datapath instance, using valid/ready handshakes on both sides.
//  Owns the accumulator register, the element counter and the adder operand registers.
//  It sits between the multiplier stream and the activation/output stage of a conv unit.
// PARAMETERS
//  LEN_W    6   width of the element-count field; lengths 0..2**LEN_W-1
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  reset      in   1      synchronous, active-high reset
//  start      in   1      one-cycle pulse that begins an accumulation; sampled only in IDLE
//  len        in   LEN_W  number of elements to sum; sampled together with start
//  in_valid   in   1      in_data valid
//  in_data    in   32     FP32 element
//  in_ready   out  1      controller accepts in_data this cycle
//  out_valid  out  1      sum available
//  out_data   out  32     FP32 sum
//  out_ready  in   1      consumer takes the sum
//  busy       out  1      high whenever state != IDLE
//  add_a      out  32     registered operand A to fp_add
//  add_b      out  32     registered operand B to fp_add
//  add_sum    in   32     {sign,exponent,mantissa} from fp_add; combinational from add_a/add_b
// BEHAVIOUR
//  Reset: state=IDLE; acc, cnt, add_a, add_b = 0; first=0. All outputs low/zero.
//  Reset mid-operation: partial sum discarded, no out_valid, back to IDLE next cycle.
//  FSM states: IDLE, WAIT_IN, ADD, OUT.
//  - IDLE: in_ready=0. On start with len==0: acc<=32'h0, go to OUT.
//    On start with len!=0: cnt<=len, first<=1, go to WAIT_IN.
//  - WAIT_IN: in_ready=1. The element is accepted on in_valid&&in_ready.
//    If first: acc<=in_data. This bypasses the adder, which cannot represent zero.
//      Then first<=0 and cnt<=cnt-1; go to OUT if cnt==1, else stay in WAIT_IN.
//    If not first: add_a<=acc, add_b<=in_data; go to ADD.
//  - ADD: in_ready=0. Operands are held stable for the whole cycle.
//    acc<=add_sum, cnt<=cnt-1; go to OUT if cnt==1, else go to WAIT_IN.
//  - OUT: out_valid=1, out_data=acc, held until out_ready. Then go to IDLE; acc is not cleared.
//  add_a/add_b change only on an accepted non-first element. They are never updated in
//  ADD, OUT or IDLE.
//  start is ignored whenever state != IDLE; len is not re-sampled.
//  in_valid without in_ready: no effect. Gaps in in_valid stall WAIT_IN indefinitely.
//  Throughput: first element takes 1 cycle, each further element takes 2 cycles.
//  Latency with start in cycle 0, N>=1 and in_valid always high: out_valid rises in cycle 2N.
//  For len==0: out_valid rises in cycle 1 with out_data=32'h0000_0000.
//  cnt is LEN_W bits and decrements only while nonzero; it never wraps.
//  Output stage: single entry, no skid buffer.
//  Rounding/normalisation is fully owned by fp_add; the controller does no FP arithmetic.
// TESTING
//  1) len=3; inputs 3F800000, 40000000, 40400000 (1,2,3); out_ready=1.
//     -> out_data=40C00000 (6.0), out_valid in cycle 6.
//  2) len=1; input 4120_0000 (10.0) -> out_data=41200000 in cycle 2; add_a/add_b remain 0.
//  3) len=0 -> out_valid in cycle 1, out_data=00000000, in_ready never asserted.
//  4) len=2; inputs 40A00000 (5.0), C0000000 (-2.0) -> out_data=40400000 (3.0).
//  5) len=4 with in_valid toggling every other cycle, and out_ready held low 5 cycles:
//     -> correct sum; out_data stable while out_valid&&!out_ready; start pulses while
//        busy are ignored.
//  6) reset asserted in ADD after 2 of 4 elements -> next cycle IDLE, all outputs 0;
//     a new len=1 run then completes normally.

Source files
------------

// File: rtl/fp_accum_ctrl.sv
// fp_accum_ctrl: sequences an FP32 stream through one shared, external fp_add.
// Owns the accumulator, the element counter and the registered adder operands.
// The first element is loaded straight into acc, so the adder never has to produce zero.
// Each further element takes two cycles: one to capture the operands, one to absorb the sum.
module fp_accum_ctrl #(
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_sum
);

  typedef enum logic [1:0] {IDLE, WAIT_IN, ADD, OUT} state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [LEN_W-1:0] cnt;
  logic             first;

  // Handshake outputs are pure decodes of the state register, so they carry no input paths.
  assign in_ready  = (state == WAIT_IN);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign out_data  = acc;

  // Sequencer: state, accumulator, counter and operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      first <= 1'b0;
      add_a <= '0;
      add_b <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              acc   <= '0;
              state <= OUT;
            end else begin
              cnt   <= len;
              first <= 1'b1;
              state <= WAIT_IN;
            end
          end
        end
        WAIT_IN: begin
          if (in_valid) begin
            if (first) begin
              // First element bypasses the adder.
              acc   <= in_data;
              first <= 1'b0;
              if (cnt != '0) cnt <= cnt - 1'b1;
              state <= (cnt == LEN_W'(1)) ? OUT : WAIT_IN;
            end else begin
              add_a <= acc;
              add_b <= in_data;
              state <= ADD;
            end
          end
        end
        ADD: begin
          // Operands have been stable since the previous edge; take the adder result.
          acc <= add_sum;
          if (cnt != '0) cnt <= cnt - 1'b1;
          state <= (cnt == LEN_W'(1)) ? OUT : WAIT_IN;
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Bench for fp_accum_ctrl: behavioural fp_add model, table-driven runs, then
// hand-written sequences for backpressure/stalls and reset in the middle of a sum.
module tb_fp_accum_ctrl;
  localparam int LEN_W = 6;

  logic             clk = 0;
  logic             reset, start, in_valid, out_ready;
  logic [LEN_W-1:0] len;
  logic [31:0]      in_data;
  logic             in_ready, out_valid, busy;
  logic [31:0]      out_data, add_a, add_b, add_sum;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_accum_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .add_a(add_a), .add_b(add_b), .add_sum(add_sum)
  );

  // FP32 <-> real, exact for the normal values used here.
  function automatic real f2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // Combinational adder model, as fp_add would behave.
  assign add_sum = r2f(f2r(add_a) + f2r(add_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string            name;
    logic [LEN_W-1:0] len;
    logic [3:0][31:0] data;     // element k in data[k]
    logic [31:0]      exp_sum;
    int               exp_cyc;  // cycle out_valid rises, start in cycle 0
    logic [31:0]      exp_a;
    logic [31:0]      exp_b;
  } vec_t;

  // One accumulation with in_valid always high and out_ready high.
  task automatic run_vec(input vec_t v);
    int cyc = 0;
    int idx = 0;
    bit got = 0;
    bit rdy_seen = 0;
    bit fire;
    start = 1; len = v.len; in_valid = 1; in_data = v.data[0]; out_ready = 1;
    for (int k = 0; k < 200 && !got; k++) begin
      fire = in_ready && in_valid;
      @(posedge clk); #1;
      cyc++;
      start = 0;
      if (fire) idx++;
      in_data = (idx < 4) ? v.data[idx] : 32'h0;
      if (in_ready) rdy_seen = 1;
      if (out_valid) begin
        got = 1;
        chk({v.name, " sum"}, out_data, v.exp_sum);
        chk({v.name, " latency"}, cyc, v.exp_cyc);
      end
    end
    if (!got) chk({v.name, " timeout"}, 0, 1);
    chk({v.name, " in_ready seen"}, {31'd0, rdy_seen}, {31'd0, v.len != 0});
    chk({v.name, " add_a"}, add_a, v.exp_a);
    chk({v.name, " add_b"}, add_b, v.exp_b);
    in_valid = 0;
    @(posedge clk); #1;
    chk({v.name, " idle after out"}, {30'd0, busy, out_valid}, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"len1", 6'd1, {32'h0, 32'h0, 32'h0, 32'h41200000}, 32'h41200000, 2, 32'h0, 32'h0};
    vecs[1] = '{"len3", 6'd3, {32'h0, 32'h40400000, 32'h40000000, 32'h3F800000}, 32'h40C00000, 6,
                32'h40400000, 32'h40400000};
    vecs[2] = '{"len0", 6'd0, {32'h0, 32'h0, 32'h0, 32'h0}, 32'h0, 1, 32'h40400000, 32'h40400000};
    vecs[3] = '{"len2neg", 6'd2, {32'h0, 32'h0, 32'hC0000000, 32'h40A00000}, 32'h40400000, 4,
                32'h40A00000, 32'hC0000000};
    vecs[4] = '{"len2frac", 6'd2, {32'h0, 32'h0, 32'h40200000, 32'h3FC00000}, 32'h40800000, 4,
                32'h3FC00000, 32'h40200000};
    vecs[5] = '{"len4", 6'd4, {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, 32'h41200000, 8,
                32'h40C00000, 32'h40800000};

    reset = 1; start = 0; len = '0; in_valid = 0; in_data = '0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'd0);
    chk("reset out_data", out_data, 32'h0);
    chk("reset add_a", add_a, 32'h0);
    chk("reset add_b", add_b, 32'h0);
    reset = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Stalled input, start pulses while busy, and output backpressure.
    begin
      logic [3:0][31:0] d;
      logic [31:0] held;
      int idx = 0;
      int n = 0;
      bit got = 0;
      bit fire;
      d = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
      start = 1; len = 6'd4; out_ready = 0; in_valid = 0; in_data = d[0];
      for (int k = 0; k < 200 && !got; k++) begin
        fire = in_ready && in_valid;
        @(posedge clk); #1;
        n++;
        if (fire) idx++;
        in_data = (idx < 4) ? d[idx] : 32'h0;
        in_valid = n[0];
        start = (n % 3 == 0);
        len = 6'd0;
        if (out_valid) got = 1;
      end
      start = 0; in_valid = 0;
      if (!got) chk("stall timeout", 0, 1);
      chk("stall sum", out_data, 32'h41200000);
      held = out_data;
      for (int k = 0; k < 5; k++) begin
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("hold out_valid", {31'd0, out_valid}, 32'd1);
        chk("hold out_data", out_data, held);
      end
      out_ready = 1;
      @(posedge clk); #1;
      chk("stall released", {30'd0, busy, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("stall stays idle", {30'd0, busy, out_valid}, 32'd0);
    end

    // Reset while in ADD after two of four elements.
    begin
      start = 1; len = 6'd4; in_valid = 1; in_data = 32'h3F800000; out_ready = 1;
      @(posedge clk); #1; start = 0;        // cycle 1: WAIT_IN, first element
      @(posedge clk); #1; in_data = 32'h40000000; // cycle 2: second element
      @(posedge clk); #1;                   // cycle 3: ADD
      chk("pre-reset in ADD", {30'd0, busy, in_ready}, 32'd2);
      chk("pre-reset add_b", add_b, 32'h40000000);
      reset = 1; in_valid = 0;
      @(posedge clk); #1;
      reset = 0;
      chk("mid reset flags", {29'd0, in_ready, out_valid, busy}, 32'd0);
      chk("mid reset out_data", out_data, 32'h0);
      chk("mid reset add_a", add_a, 32'h0);
      chk("mid reset add_b", add_b, 32'h0);
      @(posedge clk); #1;
      run_vec(vecs[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so a hung DUT cannot stall the run.
  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
